// File: rtl/ysyx_22041461_pkg.sv
// rtl/ysyx_22041461_pkg.sv - shared LSU state encoding, funct3 constants and byte-mask helper
package ysyx_22041461_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // 111 and a 011 store both fall through to the double-word mask
  function automatic logic [7:0] base_mask(input logic [2:0] funct3);
    logic [7:0] m;
    case (funct3)
      F3_LB, F3_LBU: m = 8'h01;
      F3_LH, F3_LHU: m = 8'h03;
      F3_LW, F3_LWU: m = 8'h0F;
      F3_LD:         m = 8'hFF;
      default:       m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22041461_load_align.sv
// rtl/ysyx_22041461_load_align.sv - shifts the cache word down by the byte offset and sign/zero-extends
module ysyx_22041461_load_align
  import ysyx_22041461_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] sh;

  always_comb begin
    sh = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   data = {{56{sh[7]}},  sh[7:0]};
      F3_LH:   data = {{48{sh[15]}}, sh[15:0]};
      F3_LW:   data = {{32{sh[31]}}, sh[31:0]};
      F3_LBU:  data = {56'd0, sh[7:0]};
      F3_LHU:  data = {48'd0, sh[15:0]};
      F3_LWU:  data = {32'd0, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22041461_lsu.sv
// rtl/ysyx_22041461_lsu.sv - one-op-at-a-time load/store unit between execute and the data cache
module ysyx_22041461_lsu
  import ysyx_22041461_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_misalign,
  output logic        DCACHE_valid,
  output logic [63:0] DCACHE_addr,
  output logic [63:0] DCACHE_wdata,
  output logic [7:0]  DCACHE_mask,
  output logic        DCACHE_wen,
  input  logic        DCACHE_valid_out,
  input  logic [63:0] DCACHE_rdata
);

  lsu_state_t state;
  logic [2:0] cap_funct3;
  logic [2:0] cap_offset;
  logic       cap_is_load;

  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic [2:0] offset;
  logic [3:0] size_bytes;
  logic       misalign;
  logic [63:0] load_data;

  // both kind bits set is treated as a load
  assign is_load    = in_is_load;
  assign is_store   = in_is_store & ~in_is_load;
  assign is_mem     = is_load | is_store;
  assign offset     = in_addr[2:0];
  assign size_bytes = 4'd1 << in_funct3[1:0];
  assign misalign   = is_mem && (({1'b0, offset} + size_bytes) > 4'd8);
  assign in_ready   = (state == IDLE);

  ysyx_22041461_load_align u_align (
    .rdata  (DCACHE_rdata),
    .offset (cap_offset),
    .funct3 (cap_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cap_funct3   <= 3'd0;
      cap_offset   <= 3'd0;
      cap_is_load  <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= 64'd0;
      out_rd       <= 5'd0;
      out_misalign <= 1'b0;
      DCACHE_valid <= 1'b0;
      DCACHE_addr  <= 64'd0;
      DCACHE_wdata <= 64'd0;
      DCACHE_mask  <= 8'd0;
      DCACHE_wen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_funct3   <= in_funct3;
            cap_offset   <= offset;
            cap_is_load  <= is_load;
            out_rd       <= in_rd;
            out_data     <= 64'd0;
            out_misalign <= misalign;
            if (!is_mem || misalign) begin
              state     <= RESP;
              out_valid <= 1'b1;
            end else begin
              state        <= REQ;
              DCACHE_valid <= 1'b1;
              DCACHE_addr  <= {in_addr[63:3], 3'b000};
              DCACHE_wdata <= in_wdata << {offset, 3'b000};
              DCACHE_mask  <= base_mask(in_funct3) << offset;
              DCACHE_wen   <= is_store;
            end
          end
        end
        REQ: begin
          // dropping the request here keeps a held hit from completing twice
          if (DCACHE_valid_out) begin
            if (cap_is_load) out_data <= load_data;
            state        <= RESP;
            out_valid    <= 1'b1;
            DCACHE_valid <= 1'b0;
            DCACHE_addr  <= 64'd0;
            DCACHE_wdata <= 64'd0;
            DCACHE_mask  <= 8'd0;
            DCACHE_wen   <= 1'b0;
          end
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
// tb/tb_ysyx_22041461_lsu.sv - scoreboard bench for the load/store unit with a simple cache model
module tb_ysyx_22041461_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [63:0] in_addr = 64'd0;
  logic [63:0] in_wdata = 64'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_misalign;
  logic        DCACHE_valid;
  logic [63:0] DCACHE_addr;
  logic [63:0] DCACHE_wdata;
  logic [7:0]  DCACHE_mask;
  logic        DCACHE_wen;
  logic        DCACHE_valid_out;
  logic [63:0] DCACHE_rdata;

  ysyx_22041461_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_misalign(out_misalign),
    .DCACHE_valid(DCACHE_valid), .DCACHE_addr(DCACHE_addr), .DCACHE_wdata(DCACHE_wdata),
    .DCACHE_mask(DCACHE_mask), .DCACHE_wen(DCACHE_wen),
    .DCACHE_valid_out(DCACHE_valid_out), .DCACHE_rdata(DCACHE_rdata)
  );

  always #5 clk = ~clk;

  // cache model: registered completion pulse after miss_extra additional cycles
  int          miss_extra = 0;
  int          cnt = 0;
  logic        vo = 1'b0;
  logic [63:0] cache_rdata = 64'd0;
  assign DCACHE_valid_out = vo;
  assign DCACHE_rdata = cache_rdata;

  always @(posedge clk) begin
    if (rst || !DCACHE_valid) begin
      vo  <= 1'b0;
      cnt <= 0;
    end else begin
      cnt <= cnt + 1;
      vo  <= (cnt == miss_extra);
    end
  end

  int          dv_total = 0;
  logic [63:0] snap_addr, snap_wdata;
  logic [7:0]  snap_mask;
  logic        snap_wen;
  always @(negedge clk) begin
    if (DCACHE_valid) begin
      dv_total++;
      snap_addr  = DCACHE_addr;
      snap_wdata = DCACHE_wdata;
      snap_mask  = DCACHE_mask;
      snap_wen   = DCACHE_wen;
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [63:0] ref_load(input logic [63:0] w, input logic [2:0] f3, input logic [2:0] off);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i < n && (int'(off) + i) < 8) v[8*i +: 8] = w[8*(int'(off) + i) +: 8];
    if (n < 8 && !f3[2] && v[8*n-1])
      for (int i = 0; i < 8; i++)
        if (i >= n) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input logic [63:0] rdata, output int lat, output int dv_cnt);
    int dv0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL in_ready_before_issue got=%b want=1", in_ready);
      n_fail++;
    end
    dv0 = dv_total;
    in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_rd = rd; cache_rdata = rdata;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    dv_cnt = dv_total - dv0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL out_valid_timeout got=%b want=1", out_valid);
      n_fail++;
    end
  endtask

  task automatic retire(input string name);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard_empty got=empty want=entry", name);
      n_fail++;
    end else begin
      e = sb.pop_front();
      if (out_data !== e.data || out_rd !== e.rd || out_misalign !== e.mis) begin
        $display("FAIL %s_result got data=%h rd=%0d mis=%b want data=%h rd=%0d mis=%b",
                 name, out_data, out_rd, out_misalign, e.data, e.rd, e.mis);
        n_fail++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_rd !== 5'd0 || out_misalign !== 1'b0 ||
        DCACHE_valid !== 1'b0 || in_ready !== 1'b1 || DCACHE_mask !== 8'd0 || DCACHE_addr !== 64'd0) begin
      $display("FAIL reset_state got ov=%b od=%h rd=%0d mis=%b dv=%b ir=%b mask=%h want 0,0,0,0,0,1,0",
               out_valid, out_data, out_rd, out_misalign, DCACHE_valid, in_ready, DCACHE_mask);
      n_fail++;
    end
  endtask

  task automatic test_lw_hit;
    int lat, dv;
    sb.push_back('{data: 64'hFFFF_FFFF_8765_4321, rd: 5'd3, mis: 1'b0});
    do_op(1, 0, 3'b010, 64'h8000_0004, 64'd0, 5'd3, 64'h8765_4321_0000_0000, lat, dv);
    n_checks++;
    if (lat != 3) begin $display("FAIL lw_latency got=%0d want=3", lat); n_fail++; end
    n_checks++;
    if (snap_addr !== 64'h8000_0000 || snap_mask !== 8'hF0 || snap_wen !== 1'b0) begin
      $display("FAIL lw_request got addr=%h mask=%h wen=%b want 80000000 f0 0", snap_addr, snap_mask, snap_wen);
      n_fail++;
    end
    n_checks++;
    if (dv != 2) begin $display("FAIL lw_req_cycles got=%0d want=2", dv); n_fail++; end
    retire("lw_hit");
  endtask

  task automatic test_lbu_lb;
    int lat, dv;
    sb.push_back('{data: 64'h0000_0000_0000_00F0, rd: 5'd4, mis: 1'b0});
    do_op(1, 0, 3'b100, 64'h8000_0007, 64'd0, 5'd4, 64'hF012_3456_789A_BCDE, lat, dv);
    retire("lbu");
    sb.push_back('{data: 64'hFFFF_FFFF_FFFF_FFF0, rd: 5'd5, mis: 1'b0});
    do_op(1, 0, 3'b000, 64'h8000_0007, 64'd0, 5'd5, 64'hF012_3456_789A_BCDE, lat, dv);
    n_checks++;
    if (snap_mask !== 8'h80) begin $display("FAIL lb_mask got=%h want=80", snap_mask); n_fail++; end
    retire("lb");
  endtask

  task automatic test_store;
    int lat, dv;
    sb.push_back('{data: 64'd0, rd: 5'd0, mis: 1'b0});
    do_op(0, 1, 3'b001, 64'h8000_0002, 64'h0000_0000_0000_BEEF, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, lat, dv);
    n_checks++;
    if (snap_mask !== 8'h0C || snap_wdata !== 64'h0000_0000_BEEF_0000 || snap_wen !== 1'b1 ||
        snap_addr !== 64'h8000_0000) begin
      $display("FAIL sh_request got mask=%h wdata=%h wen=%b addr=%h want 0c 00000000beef0000 1 80000000",
               snap_mask, snap_wdata, snap_wen, snap_addr);
      n_fail++;
    end
    n_checks++;
    if (DCACHE_mask !== 8'd0 || DCACHE_wen !== 1'b0) begin
      $display("FAIL sh_outputs_cleared got mask=%h wen=%b want 00 0", DCACHE_mask, DCACHE_wen);
      n_fail++;
    end
    retire("sh_store");
  endtask

  task automatic test_misalign;
    int lat, dv;
    sb.push_back('{data: 64'd0, rd: 5'd7, mis: 1'b1});
    do_op(1, 0, 3'b010, 64'h8000_0006, 64'd0, 5'd7, 64'h1234_5678_9ABC_DEF0, lat, dv);
    n_checks++;
    if (lat != 1 || dv != 0) begin
      $display("FAIL misalign_timing got lat=%0d dv=%0d want lat=1 dv=0", lat, dv);
      n_fail++;
    end
    retire("misalign");
  endtask

  task automatic test_passthrough;
    int lat, dv;
    sb.push_back('{data: 64'd0, rd: 5'd9, mis: 1'b0});
    do_op(0, 0, 3'b011, 64'h8000_0005, 64'h55, 5'd9, 64'hAAAA, lat, dv);
    n_checks++;
    if (lat != 1 || dv != 0) begin
      $display("FAIL passthrough_timing got lat=%0d dv=%0d want lat=1 dv=0", lat, dv);
      n_fail++;
    end
    retire("passthrough");
  endtask

  task automatic test_miss;
    int lat, dv;
    miss_extra = 2;
    sb.push_back('{data: 64'h0123_4567_89AB_CDEF, rd: 5'd11, mis: 1'b0});
    do_op(1, 0, 3'b011, 64'h8000_0008, 64'd0, 5'd11, 64'h0123_4567_89AB_CDEF, lat, dv);
    n_checks++;
    if (lat != 5) begin $display("FAIL miss_latency got=%0d want=5", lat); n_fail++; end
    miss_extra = 0;
    retire("ld_miss");
  endtask

  task automatic test_backpressure;
    int lat, dv;
    logic [63:0] want;
    want = 64'hFFFF_FFFF_FFFF_8001;
    sb.push_back('{data: want, rd: 5'd12, mis: 1'b0});
    do_op(1, 0, 3'b001, 64'h8000_0010, 64'd0, 5'd12, 64'h0000_0000_0000_8001, lat, dv);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== want || out_rd !== 5'd12 || in_ready !== 1'b0 ||
          DCACHE_valid !== 1'b0) begin
        $display("FAIL backpressure_cycle%0d got ov=%b od=%h rd=%0d ir=%b dv=%b want 1 %h 12 0 0",
                 i, out_valid, out_data, out_rd, in_ready, DCACHE_valid, want);
        n_fail++;
      end
    end
    retire("backpressure");
  endtask

  task automatic test_reset_mid;
    int lat, dv;
    miss_extra = 20;
    @(negedge clk);
    in_is_load = 1; in_is_store = 0; in_funct3 = 3'b010;
    in_addr = 64'h8000_0020; in_rd = 5'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (DCACHE_valid !== 1'b1) begin $display("FAIL reset_mid_inreq got=%b want=1", DCACHE_valid); n_fail++; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (DCACHE_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || DCACHE_mask !== 8'd0) begin
      $display("FAIL reset_mid_state got dv=%b ir=%b ov=%b mask=%h want 0 1 0 00",
               DCACHE_valid, in_ready, out_valid, DCACHE_mask);
      n_fail++;
    end
    miss_extra = 0;
    sb.push_back('{data: 64'h0000_0000_DEAD_BEEF, rd: 5'd14, mis: 1'b0});
    do_op(1, 0, 3'b110, 64'h8000_0024, 64'd0, 5'd14, 64'hDEAD_BEEF_0000_0000, lat, dv);
    n_checks++;
    if (lat != 3) begin $display("FAIL post_reset_latency got=%0d want=3", lat); n_fail++; end
    retire("post_reset");
  endtask

  task automatic test_back_to_back;
    int lat, dv;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] w;
    logic [4:0]  rd;
    for (int k = 0; k < 12; k++) begin
      f3 = 3'($urandom_range(0, 6));
      off = 3'($urandom_range(0, 7));
      off = off & ~3'((1 << f3[1:0]) - 1);
      w = {$urandom, $urandom};
      rd = 5'($urandom_range(1, 31));
      miss_extra = $urandom_range(0, 3);
      sb.push_back('{data: ref_load(w, f3, off), rd: rd, mis: 1'b0});
      do_op(1, 0, f3, {61'h1000_0040, off}, 64'd0, rd, w, lat, dv);
      n_checks++;
      if (lat != 3 + miss_extra) begin
        $display("FAIL b2b_latency%0d got=%0d want=%0d", k, lat, 3 + miss_extra);
        n_fail++;
      end
      retire("back_to_back");
    end
    miss_extra = 0;
  endtask

  initial begin
    test_reset();
    test_lw_hit();
    test_lbu_lb();
    test_store();
    test_misalign();
    test_passthrough();
    test_miss();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
